// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/EX memory-port arbiter: FSM state encoding,
// parameter defaults and counter widths.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_IF = 2'd1,
        ST_WAIT_EX = 2'd2
    } arb_state_t;

    localparam int unsigned DEF_RD_LATENCY    = 1;
    localparam int unsigned DEF_MAX_EX_STREAK = 4;

    localparam int unsigned LAT_W    = 3;
    localparam int unsigned STREAK_W = 4;

    function automatic logic any_lane(input logic [3:0] en);
        return |en;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_streak.sv
// Saturating count of EX grants taken while fetch waits, plus the decision
// that forces the next grant to fetch once the streak limit is reached.
module arb_streak_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_EX_STREAK = DEF_MAX_EX_STREAK
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic ex_take,
    input  logic if_take,
    output logic if_override
);

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_EX_STREAK);

    logic [STREAK_W-1:0] ex_streak;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_streak <= '0;
        end else if (!if_req || if_take) begin
            ex_streak <= '0;
        end else if (ex_take && (ex_streak != '1)) begin
            ex_streak <= ex_streak + 1'b1;
        end
    end

    always_comb begin
        if_override = if_req && (ex_streak == STREAK_LIMIT);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch and EX load/store: one registered command
// at a time, read data routed back to its owner, fetch responses killed on flush.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned RD_LATENCY    = DEF_RD_LATENCY,
    parameter int unsigned MAX_EX_STREAK = DEF_MAX_EX_STREAK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvld,
    output logic [31:0] if_rdata,
    input  logic [3:0]  ex_rden,
    input  logic [3:0]  ex_wren,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wrdata,
    output logic        ex_gnt,
    output logic        ex_rvld,
    output logic [31:0] ex_rdata,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rden,
    output logic [3:0]  mem_wren,
    output logic [31:0] mem_wrdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        error
);

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY);

    arb_state_t       state, state_nxt;
    logic [LAT_W-1:0] lat_cnt, lat_nxt;
    logic             flushed, flushed_nxt;

    logic ex_rd_req, ex_wr_req, ex_conflict, ex_req;
    logic if_override;
    logic grant_ex, grant_if;
    logic capture_if, capture_ex, drop_if;
    logic err_set;
    logic lat_done;

    always_comb begin
        ex_rd_req   = any_lane(ex_rden);
        ex_wr_req   = any_lane(ex_wren);
        ex_conflict = ex_rd_req && ex_wr_req;
        ex_req      = (ex_rd_req || ex_wr_req) && !ex_conflict;
        lat_done    = (lat_cnt == LAT_LAST);
    end

    arb_streak_ctr #(
        .MAX_EX_STREAK(MAX_EX_STREAK)
    ) u_streak (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .ex_take    (grant_ex),
        .if_take    (grant_if),
        .if_override(if_override)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
            flushed <= 1'b0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_nxt;
            flushed <= flushed_nxt;
        end
    end

    // Stores never leave IDLE, so a store grant cycle can already arbitrate again.
    always_comb begin
        state_nxt   = state;
        lat_nxt     = lat_cnt;
        flushed_nxt = flushed;
        grant_ex    = 1'b0;
        grant_if    = 1'b0;
        capture_if  = 1'b0;
        capture_ex  = 1'b0;
        drop_if     = 1'b0;
        err_set     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                err_set     = ex_conflict;
                grant_ex    = ex_req && !if_override;
                grant_if    = if_req && !grant_ex;
                lat_nxt     = '0;
                flushed_nxt = 1'b0;
                if (grant_ex && ex_rd_req) begin
                    state_nxt = ST_WAIT_EX;
                end else if (grant_if) begin
                    state_nxt = ST_WAIT_IF;
                end
            end
            ST_WAIT_IF: begin
                flushed_nxt = flushed || if_flush;
                if (lat_done) begin
                    capture_if = 1'b1;
                    drop_if    = flushed || if_flush;
                    state_nxt  = ST_IDLE;
                    lat_nxt    = '0;
                end else begin
                    lat_nxt = lat_cnt + 1'b1;
                end
            end
            ST_WAIT_EX: begin
                if (lat_done) begin
                    capture_ex = 1'b1;
                    state_nxt  = ST_IDLE;
                    lat_nxt    = '0;
                end else begin
                    lat_nxt = lat_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_gnt     <= 1'b0;
            ex_gnt     <= 1'b0;
            mem_addr   <= '0;
            mem_rden   <= '0;
            mem_wren   <= '0;
            mem_wrdata <= '0;
            if_rvld    <= 1'b0;
            if_rdata   <= '0;
            ex_rvld    <= 1'b0;
            ex_rdata   <= '0;
            error      <= 1'b0;
        end else begin
            if_gnt <= grant_if;
            ex_gnt <= grant_ex;
            if (grant_ex) begin
                mem_addr   <= ex_addr;
                mem_rden   <= ex_rden;
                mem_wren   <= ex_wren;
                mem_wrdata <= ex_wrdata;
            end else if (grant_if) begin
                mem_addr   <= if_addr;
                mem_rden   <= '1;
                mem_wren   <= '0;
                mem_wrdata <= '0;
            end else begin
                mem_addr   <= '0;
                mem_rden   <= '0;
                mem_wren   <= '0;
                mem_wrdata <= '0;
            end
            if_rvld <= capture_if && !drop_if;
            if (capture_if && !drop_if) begin
                if_rdata <= mem_rdata;
            end
            ex_rvld <= capture_ex;
            if (capture_ex) begin
                ex_rdata <= mem_rdata;
            end
            error <= error || err_set;
        end
    end

    always_comb begin
        busy = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: RD_LATENCY=1 instance for the main flows,
// RD_LATENCY=3 instance for the long-latency and mid-read reset cases.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [3:0]  ex_rden;
    logic [3:0]  ex_wren;
    logic [31:0] ex_addr;
    logic [31:0] ex_wrdata;
    logic [31:0] mem_rdata;

    logic        if_gnt, if_rvld, ex_gnt, ex_rvld, busy, error;
    logic [31:0] if_rdata, ex_rdata, mem_addr, mem_wrdata;
    logic [3:0]  mem_rden, mem_wren;

    logic        if_gnt_3, if_rvld_3, ex_gnt_3, ex_rvld_3, busy_3, error_3;
    logic [31:0] if_rdata_3, ex_rdata_3, mem_addr_3, mem_wrdata_3;
    logic [3:0]  mem_rden_3, mem_wren_3;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .RD_LATENCY   (1),
        .MAX_EX_STREAK(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvld(if_rvld), .if_rdata(if_rdata),
        .ex_rden(ex_rden), .ex_wren(ex_wren), .ex_addr(ex_addr), .ex_wrdata(ex_wrdata),
        .ex_gnt(ex_gnt), .ex_rvld(ex_rvld), .ex_rdata(ex_rdata),
        .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_wrdata(mem_wrdata), .mem_rdata(mem_rdata),
        .busy(busy), .error(error)
    );

    mem_port_arbiter #(
        .RD_LATENCY   (3),
        .MAX_EX_STREAK(4)
    ) dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt_3), .if_rvld(if_rvld_3), .if_rdata(if_rdata_3),
        .ex_rden(ex_rden), .ex_wren(ex_wren), .ex_addr(ex_addr), .ex_wrdata(ex_wrdata),
        .ex_gnt(ex_gnt_3), .ex_rvld(ex_rvld_3), .ex_rdata(ex_rdata_3),
        .mem_addr(mem_addr_3), .mem_rden(mem_rden_3), .mem_wren(mem_wren_3),
        .mem_wrdata(mem_wrdata_3), .mem_rdata(mem_rdata),
        .busy(busy_3), .error(error_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        ex_rden = '0; ex_wren = '0; ex_addr = '0; ex_wrdata = '0; mem_rdata = '0;
        tick(); tick();

        // reset state, both instances
        chk("rst_ctl",   {if_gnt, ex_gnt, if_rvld, ex_rvld, busy, error, mem_rden, mem_wren}, '0);
        chk("rst_data",  if_rdata | ex_rdata | mem_addr | mem_wrdata, '0);
        chk("rst3_ctl",  {if_gnt_3, ex_gnt_3, if_rvld_3, ex_rvld_3, busy_3, error_3, mem_rden_3, mem_wren_3}, '0);
        rst = 1'b0;

        // single fetch
        if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'h0050_0093;
        tick();
        chk("f1_if_gnt", if_gnt, 1);
        chk("f1_ex_gnt", ex_gnt, 0);
        chk("f1_addr",   mem_addr, 32'h100);
        chk("f1_rden",   mem_rden, 4'hF);
        chk("f1_wren",   mem_wren, 4'h0);
        if_req = 1'b0;
        tick();
        chk("f1_c2_rvld", if_rvld, 0);
        chk("f1_c2_busy", busy, 1);
        chk("f1_c2_rden", mem_rden, 4'h0);
        chk("f1_c2_gnt",  if_gnt, 0);
        tick();
        chk("f1_rvld",  if_rvld, 1);
        chk("f1_rdata", if_rdata, 32'h0050_0093);
        chk("f1_busy",  busy, 0);
        tick();
        chk("f1_rvld_pulse", if_rvld, 0);
        chk("f1_rdata_hold", if_rdata, 32'h0050_0093);

        // simultaneous fetch and EX load: EX first
        if_req = 1'b1; if_addr = 32'h104;
        ex_rden = 4'hF; ex_addr = 32'h2000; mem_rdata = 32'hCAFE_0001;
        tick();
        chk("s_ex_gnt", ex_gnt, 1);
        chk("s_if_gnt", if_gnt, 0);
        chk("s_addr",   mem_addr, 32'h2000);
        chk("s_rden",   mem_rden, 4'hF);
        ex_rden = '0;
        tick();
        chk("s_busy", busy, 1);
        tick();
        chk("s_ex_rvld",  ex_rvld, 1);
        chk("s_ex_rdata", ex_rdata, 32'hCAFE_0001);
        chk("s_if_rvld",  if_rvld, 0);
        chk("s_if_gnt_early", if_gnt, 0);
        mem_rdata = 32'h1111_2222;
        tick();
        chk("s_if_gnt2", if_gnt, 1);
        chk("s_addr2",   mem_addr, 32'h104);
        chk("s_ex_rvld_pulse", ex_rvld, 0);
        if_req = 1'b0;
        tick(); tick();
        chk("s_if_rvld2", if_rvld, 1);
        chk("s_if_rdata", if_rdata, 32'h1111_2222);
        chk("s_ex_hold",  ex_rdata, 32'hCAFE_0001);

        // continuous stores with fetch pending: 4 EX grants then fetch
        if_req = 1'b1; if_addr = 32'h200;
        ex_wren = 4'h3; ex_addr = 32'h3000; ex_wrdata = 32'hDEAD_BEEF; mem_rdata = 32'h3333_4444;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("st_ex_gnt_%0d", i), ex_gnt, 1);
            chk($sformatf("st_if_gnt_%0d", i), if_gnt, 0);
            chk($sformatf("st_busy_%0d", i), busy, 0);
        end
        chk("st_wren",   mem_wren, 4'h3);
        chk("st_wrdata", mem_wrdata, 32'hDEAD_BEEF);
        chk("st_rden",   mem_rden, 4'h0);
        tick();
        chk("st_if_gnt", if_gnt, 1);
        chk("st_ex_gnt_off", ex_gnt, 0);
        chk("st_if_addr", mem_addr, 32'h200);
        if_req = 1'b0;
        tick();
        chk("st_c6_ex_gnt", ex_gnt, 0);
        tick();
        chk("st_c7_ex_gnt", ex_gnt, 0);
        chk("st_if_rvld",   if_rvld, 1);
        tick();
        chk("st_ex_resume", ex_gnt, 1);
        chk("st_resume_wd", mem_wrdata, 32'hDEAD_BEEF);
        ex_wren = '0;
        tick();
        chk("st_ex_stop", ex_gnt, 0);
        chk("st_wren_off", mem_wren, 4'h0);

        // fetch flushed one cycle after grant
        if_req = 1'b1; if_addr = 32'h300; mem_rdata = 32'h5555_6666;
        tick();
        chk("fl_if_gnt", if_gnt, 1);
        if_req = 1'b0;
        tick();
        chk("fl_busy", busy, 1);
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        chk("fl_no_rvld", if_rvld, 0);
        chk("fl_busy_off", busy, 0);
        chk("fl_rdata_hold", if_rdata, 32'h3333_4444);
        if_req = 1'b1; if_addr = 32'h304; mem_rdata = 32'h7777_8888;
        tick();
        chk("fl_next_gnt",  if_gnt, 1);
        chk("fl_next_addr", mem_addr, 32'h304);
        if_req = 1'b0;
        tick(); tick();
        chk("fl_next_rvld",  if_rvld, 1);
        chk("fl_next_rdata", if_rdata, 32'h7777_8888);

        // read and write enables together
        ex_rden = 4'hF; ex_wren = 4'hF; ex_addr = 32'h4000;
        tick();
        chk("er_error",  error, 1);
        chk("er_ex_gnt", ex_gnt, 0);
        chk("er_cmd",    {mem_rden, mem_wren}, '0);
        chk("er_busy",   busy, 0);
        ex_rden = '0; ex_wren = '0;
        tick(); tick();
        chk("er_sticky", error, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("er_cleared", error, 0);

        // reset during a long-latency load on the RD_LATENCY=3 instance
        ex_rden = 4'hF; ex_addr = 32'h5000; mem_rdata = 32'hBAD0_BAD0;
        tick();
        chk("rl_ex_gnt3", ex_gnt_3, 1);
        chk("rl_addr3",   mem_addr_3, 32'h5000);
        ex_rden = '0;
        tick();
        chk("rl_busy3", busy_3, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rl_ctl3",  {if_gnt_3, ex_gnt_3, if_rvld_3, ex_rvld_3, busy_3, error_3, mem_rden_3, mem_wren_3}, '0);
        chk("rl_data3", if_rdata_3 | ex_rdata_3 | mem_addr_3 | mem_wrdata_3, '0);
        ex_rden = 4'hF; ex_addr = 32'h6000; mem_rdata = 32'h9999_AAAA;
        tick();
        chk("rl_no_rvld_c4", ex_rvld_3, 0);
        chk("rl_regrant3",   ex_gnt_3, 1);
        chk("rl_addr3b",     mem_addr_3, 32'h6000);
        ex_rden = '0;
        tick();
        chk("rl_no_rvld_c6", ex_rvld_3, 0);
        tick();
        chk("rl_no_rvld_c7", ex_rvld_3, 0);
        tick();
        chk("rl_no_rvld_c8", ex_rvld_3, 0);
        chk("rl_busy3_c8",   busy_3, 1);
        tick();
        chk("rl_rvld3",  ex_rvld_3, 1);
        chk("rl_rdata3", ex_rdata_3, 32'h9999_AAAA);
        chk("rl_idle3",  busy_3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
